// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read at a time, a 2-entry
// {pc, instr} buffer toward decode, and redirect handling that discards stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_e;

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
  logic        req_q, valid_q;
  logic        pop_s, push_s;
  logic [1:0]  cnt_after_pop_s;
  logic        unused_s;

  assign unused_s = ^redirect_pc[1:0];

  // Next-state, fetch PC and buffer update; redirect overrides any push or pop.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    pc0_d           = pc0_q;
    ins0_d          = ins0_q;
    pc1_d           = pc1_q;
    ins1_d          = ins1_q;
    pop_s           = (cnt_q != 2'd0) && instr_ready;
    push_s          = (state_q == REQ) && imem_ack;
    cnt_after_pop_s = cnt_q - {1'b0, pop_s};

    case (state_q)
      IDLE:    state_d = (cnt_after_pop_s < 2'd2) ? REQ : IDLE;
      REQ:     state_d = (imem_ack && (cnt_after_pop_s != 2'd0)) ? IDLE : REQ;
      DROP:    state_d = imem_ack ? REQ : DROP;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      cnt_d = 2'd0;
      pc_d  = {redirect_pc[31:2], 2'b00};
      // An unacknowledged request must still be drained before the new one starts.
      if ((state_q != IDLE) && !imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = REQ;
      end
    end else begin
      if (pop_s) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end else begin
        pc0_d  = pc0_q;
        ins0_d = ins0_q;
      end
      if (push_s) begin
        if (cnt_after_pop_s == 2'd0) begin
          pc0_d  = pc_q;
          ins0_d = imem_rdata;
        end else begin
          pc1_d  = pc_q;
          ins1_d = imem_rdata;
        end
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      cnt_d = cnt_after_pop_s + {1'b0, push_s};
    end

    // While draining, the memory still sees the old address.
    if (state_d == DROP) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  // State, PC, buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_A;
      addr_q  <= RESET_PC_A;
      cnt_q   <= 2'd0;
      pc0_q   <= 32'd0;
      ins0_q  <= 32'd0;
      pc1_q   <= 32'd0;
      ins1_q  <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
      req_q   <= (state_d != IDLE);
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = ins0_q;
  assign instr_pc    = pc0_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a queue-based fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched entries and the request in flight.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_disc;
  bit          m_live = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_addr = RESET_PC;
      m_busy = 1'b0;
      m_disc = 1'b0;
      m_live = 1'b1;
    end else if (redirect) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_busy && !imem_ack) begin
        m_disc = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_disc = 1'b0;
        m_addr = m_pc;
      end
    end else begin
      if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
      if (m_busy && imem_ack) begin
        if (!m_disc) begin
          mq.push_back('{pc: m_addr, ins: imem_rdata});
          m_pc = m_pc + 32'd4;
        end
        m_disc = 1'b0;
        m_busy = (mq.size() < 2);
        m_addr = m_pc;
      end else if (!m_busy) begin
        m_busy = (mq.size() < 2);
        m_addr = m_pc;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("req", {31'd0, imem_req}, {31'd0, m_busy});
      if (m_busy) chk("addr", imem_addr, m_addr);
      chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr", instr, mq[0].ins);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: acknowledge whatever request is now visible.
  task automatic tick_auto();
    tick();
    imem_ack   = imem_req;
    imem_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_addr(input logic [31:0] target);
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == target) break;
      tick_auto();
    end
    chk("wait_addr", imem_addr, target);
  endtask

  initial begin
    // Reset values and streaming with zero-wait memory.
    instr_ready = 1'b1;
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    rst = 1'b1;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    imem_ack = imem_req;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      tick_auto();
    end
    for (int i = 0; i < 6; i++) begin
      chk("stream_pc", instr_pc, 32'(4 * i));
      tick_auto();
    end

    // Backpressure: two entries buffered, fetch stops, then resumes in order.
    instr_ready = 1'b0;
    do_reset();
    rst = 1'b1;
    tick();
    imem_ack = imem_req;
    tick_auto();
    tick_auto();
    tick_auto();
    tick_auto();
    tick_auto();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_pc", instr_pc, 32'h0);
    chk("model_full", 32'(mq.size()), 32'd2);
    instr_ready = 1'b1;
    tick_auto();
    chk("resume_pc", instr_pc, 32'h4);
    chk("resume_addr", imem_addr, 32'h8);
    tick_auto();
    chk("resume_pc2", instr_pc, 32'h8);

    // Redirect while the request to 0x8 waits three cycles for its ack.
    do_reset();
    rst = 1'b1;
    tick();
    imem_ack = imem_req;
    wait_addr(32'h8);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect = 1'b0;
      chk("drop_addr", imem_addr, 32'h8);
      chk("drop_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_instr", instr, 32'h1111_2222);
    chk("model_redir_pc", mq[0].pc, 32'h100);

    // Redirect with ack and pop on a full buffer.
    instr_ready = 1'b0;
    do_reset();
    rst = 1'b1;
    tick();
    imem_ack = imem_req;
    tick_auto();
    tick_auto();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h40);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_1234;
    tick();
    imem_ack = 1'b0;
    chk("flush_pc", instr_pc, 32'h40);
    chk("flush_instr", instr, 32'h0000_1234);

    // Address wrap at the top of the address space.
    do_reset();
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick_auto();
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    tick_auto();
    chk("wrap_pc1", instr_pc, 32'h0000_0000);

    // Reset during an outstanding request, with acks in and after the reset cycle.
    do_reset();
    rst = 1'b1;
    tick();
    imem_ack = imem_req;
    wait_addr(32'h8);
    rst      = 1'b0;
    imem_ack = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    rst = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_addr", imem_addr, RESET_PC);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("late_ack_nopush", {31'd0, instr_valid}, 32'd0);

    // Randomized traffic, checked each cycle by the model comparison.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst         = ($urandom_range(0, 299) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      instr_ready = ($urandom_range(0, 3) != 0);
      imem_ack    = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
